// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
// Round-robin N-to-1 arbiter for the SystemBus ReadWrite channel, plus
// broadcast/collect of provider invalidation requests to all users.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   usr_rw_*  (in)        per-user ReadWrite requests, user i in slice i
//   usr_rw_ready (out)    one-hot completion pulse to the granted user
//   usr_r_data (out)      read data, shared by all users
//   usr_inv_* (out/in)    per-user invalidation request / acknowledge
//   prv_rw_* (out/in)     ReadWrite port toward the system cache
//   prv_inv_* (in/out)    invalidation request from / completion to provider
//   gnt_id (out)          index of the current or last granted user
module sysbus_arbiter #(
  parameter int NUM_USERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int IDW        = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_USERS-1:0]             usr_rw_valid,
  input  logic [NUM_USERS-1:0]             usr_rw_we,
  input  logic [NUM_USERS-1:0]             usr_w_ce,
  input  logic [NUM_USERS*ADDR_WIDTH-1:0]  usr_rw_addr,
  input  logic [NUM_USERS*MASK_WIDTH-1:0]  usr_w_mask,
  input  logic [NUM_USERS*DATA_WIDTH-1:0]  usr_w_data,
  output logic [NUM_USERS-1:0]             usr_rw_ready,
  output logic [DATA_WIDTH-1:0]            usr_r_data,
  output logic [NUM_USERS-1:0]             usr_inv_valid,
  output logic [ADDR_WIDTH-1:0]            usr_inv_addr,
  input  logic [NUM_USERS-1:0]             usr_inv_ready,
  output logic                             prv_rw_valid,
  output logic                             prv_rw_we,
  output logic                             prv_w_ce,
  output logic [ADDR_WIDTH-1:0]            prv_rw_addr,
  output logic [MASK_WIDTH-1:0]            prv_w_mask,
  output logic [DATA_WIDTH-1:0]            prv_w_data,
  input  logic                             prv_rw_ready,
  input  logic [DATA_WIDTH-1:0]            prv_r_data,
  input  logic                             prv_inv_valid,
  input  logic [ADDR_WIDTH-1:0]            prv_inv_addr,
  output logic                             prv_inv_ready,
  output logic [IDW-1:0]                   gnt_id
);

  localparam logic [0:0]     ST_IDLE = 1'b0;
  localparam logic [0:0]     ST_BUSY = 1'b1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_USERS - 1);

  logic [0:0]           r_state;
  logic [IDW-1:0]       r_rr_ptr;
  logic [IDW-1:0]       r_gnt_id;
  logic [NUM_USERS-1:0] r_ack_mask;

  logic                 w_found;
  logic [IDW-1:0]       w_pick;
  logic [NUM_USERS-1:0] w_inv_valid;
  logic [NUM_USERS-1:0] w_inv_ack;
  logic                 w_inv_done;

  // Rotating priority as two fixed-priority passes: first requesters at or
  // above rr_ptr, then wrap around to the lowest index.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned j = 0; j < NUM_USERS; j++) begin
      if (!w_found && usr_rw_valid[j] && (IDW'(j) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_pick  = IDW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_USERS; j++) begin
      if (!w_found && usr_rw_valid[j]) begin
        w_found = 1'b1;
        w_pick  = IDW'(j);
      end
    end
  end

  // Provider-side mux and completion routing; all zero outside BUSY.
  always_comb begin
    prv_rw_valid = 1'b0;
    prv_rw_we    = 1'b0;
    prv_w_ce     = 1'b0;
    prv_rw_addr  = '0;
    prv_w_mask   = '0;
    prv_w_data   = '0;
    usr_rw_ready = '0;
    if (r_state == ST_BUSY) begin
      for (int unsigned j = 0; j < NUM_USERS; j++) begin
        if (IDW'(j) == r_gnt_id) begin
          prv_rw_valid    = usr_rw_valid[j];
          prv_rw_we       = usr_rw_we[j];
          prv_w_ce        = usr_w_ce[j];
          prv_rw_addr     = usr_rw_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          prv_w_mask      = usr_w_mask[j*MASK_WIDTH +: MASK_WIDTH];
          prv_w_data      = usr_w_data[j*DATA_WIDTH +: DATA_WIDTH];
          usr_rw_ready[j] = prv_rw_ready;
        end
      end
    end
  end

  assign usr_r_data = prv_r_data;
  assign gnt_id     = r_gnt_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_found) begin
        r_gnt_id <= w_pick;
        r_state  <= ST_BUSY;
      end
    end else if (prv_rw_ready) begin
      r_rr_ptr <= (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + IDW'(1);
      r_state  <= ST_IDLE;
    end
  end

  // Invalidation broadcast: a user stops seeing the request once it has
  // acknowledged; completion fires when the last outstanding ack arrives.
  assign w_inv_valid = {NUM_USERS{prv_inv_valid}} & ~r_ack_mask;
  assign w_inv_ack   = usr_inv_ready & w_inv_valid;
  assign w_inv_done  = prv_inv_valid & (&(r_ack_mask | w_inv_ack));

  // Combinational paths from prv_inv_valid are gated so reset silences them.
  assign usr_inv_valid = w_inv_valid & {NUM_USERS{rst_n}};
  assign usr_inv_addr  = prv_inv_addr;
  assign prv_inv_ready = w_inv_done & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_mask <= '0;
    end else if (w_inv_done) begin
      r_ack_mask <= '0;
    end else begin
      r_ack_mask <= r_ack_mask | w_inv_ack;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;

  logic clk;
  logic rst_n;

  // DUT with 2 users, 128-bit data
  logic [1:0]   u2_valid, u2_we, u2_ce, u2_ready, u2_inv_valid, u2_inv_ready;
  logic [63:0]  u2_addr;
  logic [31:0]  u2_mask;
  logic [255:0] u2_data;
  logic [127:0] u2_rdata;
  logic [31:0]  u2_inv_addr;
  logic         p2_valid, p2_we, p2_ce, p2_ready, p2_inv_valid, p2_inv_ready;
  logic [31:0]  p2_addr, p2_inv_addr;
  logic [15:0]  p2_mask;
  logic [127:0] p2_wdata, p2_rdata;
  logic [0:0]   gnt2;

  // DUT with 4 users, 32-bit data
  logic [3:0]   u4_valid, u4_we, u4_ce, u4_ready, u4_inv_valid, u4_inv_ready;
  logic [127:0] u4_addr;
  logic [15:0]  u4_mask;
  logic [127:0] u4_data;
  logic [31:0]  u4_rdata;
  logic [31:0]  u4_inv_addr;
  logic         p4_valid, p4_we, p4_ce, p4_ready, p4_inv_valid, p4_inv_ready;
  logic [31:0]  p4_addr, p4_inv_addr;
  logic [3:0]   p4_mask;
  logic [31:0]  p4_wdata, p4_rdata;
  logic [1:0]   gnt4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] RD_WORD = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] WR_WORD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  sysbus_arbiter #(.NUM_USERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(128)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .usr_rw_valid(u2_valid), .usr_rw_we(u2_we), .usr_w_ce(u2_ce),
    .usr_rw_addr(u2_addr), .usr_w_mask(u2_mask), .usr_w_data(u2_data),
    .usr_rw_ready(u2_ready), .usr_r_data(u2_rdata),
    .usr_inv_valid(u2_inv_valid), .usr_inv_addr(u2_inv_addr), .usr_inv_ready(u2_inv_ready),
    .prv_rw_valid(p2_valid), .prv_rw_we(p2_we), .prv_w_ce(p2_ce),
    .prv_rw_addr(p2_addr), .prv_w_mask(p2_mask), .prv_w_data(p2_wdata),
    .prv_rw_ready(p2_ready), .prv_r_data(p2_rdata),
    .prv_inv_valid(p2_inv_valid), .prv_inv_addr(p2_inv_addr), .prv_inv_ready(p2_inv_ready),
    .gnt_id(gnt2)
  );

  sysbus_arbiter #(.NUM_USERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .usr_rw_valid(u4_valid), .usr_rw_we(u4_we), .usr_w_ce(u4_ce),
    .usr_rw_addr(u4_addr), .usr_w_mask(u4_mask), .usr_w_data(u4_data),
    .usr_rw_ready(u4_ready), .usr_r_data(u4_rdata),
    .usr_inv_valid(u4_inv_valid), .usr_inv_addr(u4_inv_addr), .usr_inv_ready(u4_inv_ready),
    .prv_rw_valid(p4_valid), .prv_rw_we(p4_we), .prv_w_ce(p4_ce),
    .prv_rw_addr(p4_addr), .prv_w_mask(p4_mask), .prv_w_data(p4_wdata),
    .prv_rw_ready(p4_ready), .prv_r_data(p4_rdata),
    .prv_inv_valid(p4_inv_valid), .prv_inv_addr(p4_inv_addr), .prv_inv_ready(p4_inv_ready),
    .gnt_id(gnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (p2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_prv_valid2: got %0h expected 0", p2_valid); end
    n_checks++; if (u2_ready !== 2'b00) begin n_fail++; $display("FAIL reset_usr_ready2: got %0h expected 0", u2_ready); end
    n_checks++; if (u2_inv_valid !== 2'b00) begin n_fail++; $display("FAIL reset_inv_valid2: got %0h expected 0", u2_inv_valid); end
    n_checks++; if (p2_inv_ready !== 1'b0) begin n_fail++; $display("FAIL reset_inv_ready2: got %0h expected 0", p2_inv_ready); end
    n_checks++; if (gnt2 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt2: got %0h expected 0", gnt2); end
    n_checks++; if (gnt4 !== 2'd0) begin n_fail++; $display("FAIL reset_gnt4: got %0h expected 0", gnt4); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // User1 write to 0x1000, provider ready 3 cycles after valid.
  task automatic test_single_request();
    u2_valid = 2'b10; u2_we = 2'b10; u2_ce = 2'b10;
    u2_addr  = {32'h0000_1000, 32'h0};
    u2_mask  = {16'hFFFF, 16'h0};
    u2_data  = {WR_WORD, 128'h0};
    #1;
    n_checks++; if (p2_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %0h expected 0", p2_valid); end
    tick();
    n_checks++; if (p2_valid !== 1'b1) begin n_fail++; $display("FAIL single_prv_valid: got %0h expected 1", p2_valid); end
    n_checks++; if (p2_addr !== 32'h1000) begin n_fail++; $display("FAIL single_prv_addr: got %0h expected 1000", p2_addr); end
    n_checks++; if ({p2_we, p2_ce} !== 2'b11) begin n_fail++; $display("FAIL single_we_ce: got %0h expected 3", {p2_we, p2_ce}); end
    n_checks++; if (p2_wdata !== WR_WORD) begin n_fail++; $display("FAIL single_wdata: got %0h expected %0h", p2_wdata, WR_WORD); end
    n_checks++; if (p2_mask !== 16'hFFFF) begin n_fail++; $display("FAIL single_mask: got %0h expected ffff", p2_mask); end
    n_checks++; if (gnt2 !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %0h expected 1", gnt2); end
    tick();
    tick();
    n_checks++; if (u2_ready !== 2'b00) begin n_fail++; $display("FAIL single_early_ready: got %0h expected 0", u2_ready); end
    tick();
    p2_ready = 1'b1;
    #1;
    n_checks++; if (u2_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %0h expected 2", u2_ready); end
    tick();
    p2_ready = 1'b0; u2_valid = 2'b00; u2_we = 2'b00; u2_ce = 2'b00;
    #1;
    n_checks++; if (p2_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid: got %0h expected 0", p2_valid); end
    n_checks++; if (p2_addr !== 32'h0) begin n_fail++; $display("FAIL single_after_addr: got %0h expected 0", p2_addr); end
  endtask

  // Both users request continuously starting with rr_ptr=0.
  task automatic test_contention();
    logic [1:0] exp_rdy;
    logic       exp_g;
    u2_valid = 2'b11;
    u2_addr  = {32'h0000_0200, 32'h0000_0100};
    for (int i = 0; i < 4; i++) begin
      exp_g   = (i % 2 == 1);
      exp_rdy = exp_g ? 2'b10 : 2'b01;
      #1;
      n_checks++; if (p2_valid !== 1'b0) begin n_fail++; $display("FAIL contention_idle_gap[%0d]: got %0h expected 0", i, p2_valid); end
      tick();
      n_checks++; if (gnt2 !== exp_g) begin n_fail++; $display("FAIL contention_gnt[%0d]: got %0h expected %0h", i, gnt2, exp_g); end
      n_checks++; if (p2_addr !== (exp_g ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL contention_addr[%0d]: got %0h", i, p2_addr); end
      p2_ready = 1'b1;
      #1;
      n_checks++; if (u2_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_ready[%0d]: got %0h expected %0h", i, u2_ready, exp_rdy); end
      tick();
      p2_ready = 1'b0;
    end
    u2_valid = 2'b00;
  endtask

  task automatic test_read_data();
    u2_valid = 2'b01; u2_we = 2'b00;
    tick();
    n_checks++; if (gnt2 !== 1'b0) begin n_fail++; $display("FAIL read_gnt: got %0h expected 0", gnt2); end
    n_checks++; if (p2_we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %0h expected 0", p2_we); end
    p2_rdata = RD_WORD;
    p2_ready = 1'b1;
    #1;
    n_checks++; if (u2_ready !== 2'b01) begin n_fail++; $display("FAIL read_ready: got %0h expected 1", u2_ready); end
    n_checks++; if (u2_rdata !== RD_WORD) begin n_fail++; $display("FAIL read_data: got %0h expected %0h", u2_rdata, RD_WORD); end
    tick();
    p2_ready = 1'b0;
    // rr_ptr is now 1; a lone user0 request must wrap around to it.
    #1;
    tick();
    n_checks++; if ({p2_valid, gnt2} !== 2'b10) begin n_fail++; $display("FAIL read_wrap_gnt: got %0h expected 2", {p2_valid, gnt2}); end
    p2_ready = 1'b1;
    tick();
    p2_ready = 1'b0; u2_valid = 2'b00;
  endtask

  // Granted user drops valid early while the other requests: grant stays.
  task automatic test_grant_hold();
    u2_valid = 2'b10;
    u2_addr  = {32'h0000_00A0, 32'h0000_00B0};
    tick();
    u2_valid = 2'b01;
    #1;
    n_checks++; if (p2_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %0h expected 0", p2_valid); end
    n_checks++; if (p2_addr !== 32'hA0) begin n_fail++; $display("FAIL hold_addr: got %0h expected a0", p2_addr); end
    tick();
    n_checks++; if (gnt2 !== 1'b1) begin n_fail++; $display("FAIL hold_gnt: got %0h expected 1", gnt2); end
    p2_ready = 1'b1;
    #1;
    n_checks++; if (u2_ready !== 2'b10) begin n_fail++; $display("FAIL hold_ready: got %0h expected 2", u2_ready); end
    tick();
    p2_ready = 1'b0; u2_valid = 2'b00;
  endtask

  // N=4, acks at cycles 0,2,2,5.
  task automatic test_invalidation();
    logic [3:0] rdy_tbl  [6] = '{4'b0001, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b1000};
    logic [3:0] vld_tbl  [6] = '{4'b1111, 4'b1110, 4'b1110, 4'b1000, 4'b1000, 4'b1000};
    logic       done_tbl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    p4_inv_valid = 1'b1;
    p4_inv_addr  = 32'h2040;
    for (int c = 0; c < 6; c++) begin
      u4_inv_ready = rdy_tbl[c];
      #1;
      n_checks++; if (u4_inv_valid !== vld_tbl[c]) begin n_fail++; $display("FAIL inv_valid[c%0d]: got %0h expected %0h", c, u4_inv_valid, vld_tbl[c]); end
      n_checks++; if (p4_inv_ready !== done_tbl[c]) begin n_fail++; $display("FAIL inv_done[c%0d]: got %0h expected %0h", c, p4_inv_ready, done_tbl[c]); end
      if (c == 0) begin
        n_checks++; if (u4_inv_addr !== 32'h2040) begin n_fail++; $display("FAIL inv_addr: got %0h expected 2040", u4_inv_addr); end
      end
      tick();
    end
    p4_inv_valid = 1'b0; u4_inv_ready = 4'b0000;
    #1;
    n_checks++; if ({u4_inv_valid, p4_inv_ready} !== 5'b0) begin n_fail++; $display("FAIL inv_idle: got %0h expected 0", {u4_inv_valid, p4_inv_ready}); end
    // Acks while no broadcast is pending must be ignored.
    u4_inv_ready = 4'b1111;
    tick();
    u4_inv_ready = 4'b0000; p4_inv_valid = 1'b1;
    #1;
    n_checks++; if (u4_inv_valid !== 4'b1111) begin n_fail++; $display("FAIL inv_mask_clear: got %0h expected f", u4_inv_valid); end
    n_checks++; if (p4_inv_ready !== 1'b0) begin n_fail++; $display("FAIL inv_no_ack_done: got %0h expected 0", p4_inv_ready); end
    u4_inv_ready = 4'b1111;
    #1;
    n_checks++; if (p4_inv_ready !== 1'b1) begin n_fail++; $display("FAIL inv_all_ack_first: got %0h expected 1", p4_inv_ready); end
    tick();
    p4_inv_valid = 1'b0; u4_inv_ready = 4'b0000;
  endtask

  // RW transaction for user2 alongside an invalidation on the 4-user DUT.
  task automatic test_overlap();
    u4_valid     = 4'b0100;
    u4_addr      = {32'h0, 32'h0000_3000, 32'h0, 32'h0};
    p4_inv_valid = 1'b1;
    p4_inv_addr  = 32'h4080;
    u4_inv_ready = 4'b0111;
    #1;
    n_checks++; if ({p4_valid, p4_inv_ready} !== 2'b00) begin n_fail++; $display("FAIL overlap_start: got %0h expected 0", {p4_valid, p4_inv_ready}); end
    tick();
    u4_inv_ready = 4'b0000;
    #1;
    n_checks++; if ({p4_valid, gnt4} !== 3'b110) begin n_fail++; $display("FAIL overlap_gnt: got %0h expected 6", {p4_valid, gnt4}); end
    n_checks++; if (p4_addr !== 32'h3000) begin n_fail++; $display("FAIL overlap_addr: got %0h expected 3000", p4_addr); end
    n_checks++; if (u4_inv_valid !== 4'b1000) begin n_fail++; $display("FAIL overlap_inv_valid: got %0h expected 8", u4_inv_valid); end
    tick();
    n_checks++; if ({u4_ready, p4_inv_ready} !== 5'b0) begin n_fail++; $display("FAIL overlap_mid: got %0h expected 0", {u4_ready, p4_inv_ready}); end
    tick();
    p4_ready = 1'b1; u4_inv_ready = 4'b1000;
    #1;
    n_checks++; if (u4_ready !== 4'b0100) begin n_fail++; $display("FAIL overlap_rw_ready: got %0h expected 4", u4_ready); end
    n_checks++; if (p4_inv_ready !== 1'b1) begin n_fail++; $display("FAIL overlap_inv_ready: got %0h expected 1", p4_inv_ready); end
    tick();
    p4_ready = 1'b0; u4_valid = 4'b0000; p4_inv_valid = 1'b0; u4_inv_ready = 4'b0000;
    #1;
    n_checks++; if ({p4_valid, u4_inv_valid} !== 5'b0) begin n_fail++; $display("FAIL overlap_end: got %0h expected 0", {p4_valid, u4_inv_valid}); end
  endtask

  task automatic test_reset_mid();
    u4_valid = 4'b1000;
    p4_inv_valid = 1'b1; p4_inv_addr = 32'h5000; u4_inv_ready = 4'b0001;
    tick();
    u4_inv_ready = 4'b0000;
    #1;
    n_checks++; if ({p4_valid, gnt4} !== 3'b111) begin n_fail++; $display("FAIL rstmid_busy: got %0h expected 7", {p4_valid, gnt4}); end
    n_checks++; if (u4_inv_valid !== 4'b1110) begin n_fail++; $display("FAIL rstmid_inv_pending: got %0h expected e", u4_inv_valid); end
    rst_n = 1'b0;
    p4_ready = 1'b1;
    #1;
    n_checks++; if ({p4_valid, u4_ready} !== 5'b0) begin n_fail++; $display("FAIL rstmid_rw_off: got %0h expected 0", {p4_valid, u4_ready}); end
    n_checks++; if ({u4_inv_valid, p4_inv_ready} !== 5'b0) begin n_fail++; $display("FAIL rstmid_inv_off: got %0h expected 0", {u4_inv_valid, p4_inv_ready}); end
    n_checks++; if (gnt4 !== 2'd0) begin n_fail++; $display("FAIL rstmid_gnt: got %0h expected 0", gnt4); end
    tick();
    p4_ready = 1'b0; p4_inv_valid = 1'b0; u4_valid = 4'b1111;
    rst_n = 1'b1;
    #1;
    n_checks++; if (p4_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %0h expected 0", p4_valid); end
    tick();
    n_checks++; if ({p4_valid, gnt4} !== 3'b100) begin n_fail++; $display("FAIL rstmid_first_gnt: got %0h expected 4", {p4_valid, gnt4}); end
    p4_inv_valid = 1'b1;
    #1;
    n_checks++; if (u4_inv_valid !== 4'b1111) begin n_fail++; $display("FAIL rstmid_mask_clear: got %0h expected f", u4_inv_valid); end
    p4_ready = 1'b1;
    tick();
    p4_ready = 1'b0; u4_valid = 4'b0000; p4_inv_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    u2_valid = '0; u2_we = '0; u2_ce = '0; u2_addr = '0; u2_mask = '0; u2_data = '0;
    u2_inv_ready = '0; p2_ready = 1'b0; p2_rdata = '0; p2_inv_valid = 1'b0; p2_inv_addr = '0;
    u4_valid = '0; u4_we = '0; u4_ce = '0; u4_addr = '0; u4_mask = '0; u4_data = '0;
    u4_inv_ready = '0; p4_ready = 1'b0; p4_rdata = '0; p4_inv_valid = 1'b0; p4_inv_addr = '0;
    test_reset();
    test_single_request();
    test_contention();
    test_read_data();
    test_grant_hold();
    test_invalidation();
    test_overlap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
